// File: rtl/memwb_stage_reg.sv
// rtl/memwb_stage_reg.sv - MEM/WB pipeline register with stall/flush, one-shot write enable, halt FSM and retire counter
module memwb_stage_reg #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  RegWrite_in,
  input  logic                  ret_in,
  input  logic                  mem_to_reg_in,
  input  logic                  HALT_in,
  input  logic [REG_ADDR_W-1:0] reg_rd_in,
  input  logic [DATA_W-1:0]     mem_read_data_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  output logic                  valid_out,
  output logic                  RegWrite_out,
  output logic                  ret_out,
  output logic                  mem_to_reg_out,
  output logic                  HALT_out,
  output logic [REG_ADDR_W-1:0] reg_rd_out,
  output logic [DATA_W-1:0]     mem_read_data_out,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_we,
  output logic                  halted,
  output logic [CNT_W-1:0]      retire_cnt
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_valid;
  logic                  r_regwrite;
  logic                  r_ret;
  logic                  r_mem_to_reg;
  logic                  r_halt;
  logic                  r_fresh;
  logic [REG_ADDR_W-1:0] r_reg_rd;
  logic [DATA_W-1:0]     r_mem_data;
  logic [DATA_W-1:0]     r_alu;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_load;
  logic                  w_bubble;

  // A new entry is accepted only while running and neither flushed nor stalled.
  assign w_load   = !flush && !stall && (r_state == ST_RUN);
  // Flush always wins; a halted core keeps emitting bubbles unless stalled.
  assign w_bubble = flush || (!stall && (r_state == ST_HALTED));

  always_comb begin
    w_state_nxt = r_state;
    if (w_load && valid_in && HALT_in) begin
      w_state_nxt = ST_HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_regwrite   <= 1'b0;
      r_ret        <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_halt       <= 1'b0;
      r_fresh      <= 1'b0;
      r_reg_rd     <= '0;
      r_mem_data   <= '0;
      r_alu        <= '0;
    end else if (w_bubble) begin
      r_valid      <= 1'b0;
      r_regwrite   <= 1'b0;
      r_ret        <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_halt       <= 1'b0;
      r_fresh      <= 1'b0;
    end else if (stall) begin
      // Held entry must not write back or report HALT a second time.
      r_fresh      <= 1'b0;
      r_halt       <= 1'b0;
    end else begin
      r_valid      <= valid_in;
      r_fresh      <= valid_in;
      r_regwrite   <= RegWrite_in & valid_in;
      r_ret        <= ret_in & valid_in;
      r_mem_to_reg <= mem_to_reg_in & valid_in;
      r_halt       <= HALT_in & valid_in;
      r_reg_rd     <= reg_rd_in;
      r_mem_data   <= mem_read_data_in;
      r_alu        <= alu_result_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_load && valid_in) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign valid_out         = r_valid;
  assign RegWrite_out      = r_regwrite;
  assign ret_out           = r_ret;
  assign mem_to_reg_out    = r_mem_to_reg;
  assign HALT_out          = r_halt;
  assign reg_rd_out        = r_reg_rd;
  assign mem_read_data_out = r_mem_data;
  assign alu_result_out    = r_alu;
  assign wb_data           = r_mem_to_reg ? r_mem_data : r_alu;
  assign wb_we             = r_valid & r_regwrite & r_fresh;
  assign halted            = (r_state == ST_HALTED);
  assign retire_cnt        = r_cnt;

endmodule

// File: doc/memwb_stage_reg.md
# memwb_stage_reg

Parametrised MEM/WB pipeline register for the WISC pipeline. It carries write-back control and data from the MEM stage to the WB stage, and adds the following:
- stall and flush control;
- a per-entry valid bit;
- a one-shot register-file write enable;
- a halt state machine that freezes retirement after HALT;
- a wrapping retired-instruction counter.

It sits between the MEM stage and the register-file write port.

## Interface
Parameters:
- DATA_W, 16, width of ALU result, memory read data and write-back data
- REG_ADDR_W, 4, width of destination register address
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold current contents
- flush  in  1  squash entry being loaded (insert bubble)
- valid_in  in  1  MEM-stage entry is a real instruction
- RegWrite_in, ret_in, mem_to_reg_in, HALT_in  in  1 each  MEM-stage control
- reg_rd_in  in  REG_ADDR_W  destination register
- mem_read_data_in, alu_result_in  in  DATA_W  MEM-stage data
- valid_out  out  1  WB entry valid
- RegWrite_out, ret_out, mem_to_reg_out, HALT_out  out  1 each  registered control
- reg_rd_out  out  REG_ADDR_W  registered destination
- mem_read_data_out, alu_result_out  out  DATA_W  registered data
- wb_data  out  DATA_W  combinational: mem_to_reg_out ? mem_read_data_out : alu_result_out
- wb_we  out  1  combinational: valid_out & RegWrite_out & fresh
- halted  out  1  core halted (state HALTED)
- retire_cnt  out  CNT_W  retired-instruction count

## Operation
Internal state: fresh (1 bit) and FSM state {RUN, HALTED}.

Per-edge update priority is rst > flush > stall > HALTED > load:
- **rst:** every registered output, fresh and retire_cnt go to 0; state goes to RUN.
- **flush:**
  - valid_out, RegWrite_out, ret_out, mem_to_reg_out, HALT_out and fresh go to 0.
  - reg_rd_out and both data outputs hold.
  - state and retire_cnt hold.
- **stall (no flush):**
  - All fields hold, except fresh goes to 0 and HALT_out goes to 0, so HALT is seen once.
  - state and retire_cnt hold.
- **state HALTED (no flush/stall):**
  - Same as flush; inputs are ignored.
  - State stays HALTED until rst.
- **load (RUN, no flush/stall):**
  - Data fields and reg_rd_out load from inputs unconditionally.
  - valid_out and fresh take valid_in.
  - Each control output takes its input ANDed with valid_in.
  - If valid_in, retire_cnt increments by 1, wrapping mod 2^CNT_W.
  - If valid_in & HALT_in, state goes to HALTED.

Write-back rules:
- wb_we pulses once per valid instruction, even if the entry is later held by stall.
- wb_data is a pure mux of the registered outputs; it is defined regardless of valid_out.

## Timing
- **Latency:** inputs accepted at edge N appear on outputs after edge N; wb_we and wb_data are valid in cycle N+1.
- **Throughput:** one entry per cycle while not stalled.
- **Reset:** all outputs 0 in the cycle after rst is sampled high. wb_data is 0, since both data registers are 0.
- **Halt:**
  - The edge loading a valid HALT sets HALT_out=1 and halted=1 together.
  - The next edge clears HALT_out; halted stays 1.
  - The halting instruction itself is counted and, if RegWrite_in, written back.
- **Simultaneous events:**
  - flush with stall: flush wins.
  - flush with valid HALT: no halt, no count.
  - stall with valid HALT: no halt until it is actually loaded.
- **Counter wrap:** at all-ones, the next valid load gives 0.
- **rst while HALTED or stalled:** returns to RUN with all outputs 0 on the next cycle.

## Test plan
- **Reset:** assert rst for 2 cycles with random inputs.
  - Every output is 0, including wb_data=0x0000, retire_cnt=0 and halted=0.
- **Basic pipeline:** load valid entries in consecutive cycles.
  - Entry 1: RegWrite=1, mem_to_reg=0, alu=0x1234, rd=3.
  - Entry 2: mem_to_reg=1, mem=0xBEEF, rd=5.
  - Required: wb_data is 0x1234 then 0xBEEF, wb_we is 1 both cycles, retire_cnt is 1 then 2.
- **Stall, then flush:** load RegWrite entry rd=7, then hold stall=1 for 3 cycles.
  - During the stall: wb_we=1 only in the first cycle, outputs hold, retire_cnt is unchanged.
  - Then assert flush with a valid input: valid_out=0, wb_we=0, no count.
- **Halt:** valid HALT entry, followed by 4 more valid RegWrite entries.
  - HALT_out is 1 for exactly one cycle; halted=1 from then on.
  - Subsequent entries give valid_out=0 and wb_we=0; retire_cnt=1.
  - Asserting rst clears halted.
- **Flush priority:** same edge with flush=1, stall=1, valid HALT.
  - Required: valid_out=0, halted=0, retire_cnt unchanged.
- **Wrap:** CNT_W=4; 17 consecutive valid loads.
  - retire_cnt reads 15, then 0, then 1.
